load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/rv32_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared LSU types: FSM state encoding, funct3 access codes
// and the misalignment predicate used by LSU_MISALIGN_TRAP_EN.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic half;
    logic word;
    half = (f3[1:0] == 2'b01) && off[0];
    word = (f3[1:0] == 2'b10) && (off != 2'b00);
    return half || word;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and memory (slave):
// request/ready handshake plus response channel.
interface load_store_unit_if;

  logic        busReqValid;
  logic        busReqReady;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busWstrb;
  logic        busRespValid;
  logic [31:0] busRdata;

  modport master (
    output busReqValid,
    output busWe,
    output busAddr,
    output busWdata,
    output busWstrb,
    input  busReqReady,
    input  busRespValid,
    input  busRdata
  );

  modport slave (
    input  busReqValid,
    input  busWe,
    input  busAddr,
    input  busWdata,
    input  busWstrb,
    output busReqReady,
    output busRespValid,
    output busRdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data replication and
// load lane extraction with sign/zero extension.
import rv32_pkg::*;

module lsu_align (
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_src,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  assign lane = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      (ld_funct3 == F3_LB):
        ld_data = {{24{lane[7]}}, lane[7:0]};
      (ld_funct3 == F3_LH):
        ld_data = {{16{lane[15]}}, lane[15:0]};
      (ld_funct3 == F3_LW):
        ld_data = rdata;
      (ld_funct3 == F3_LBU):
        ld_data = {24'h0, lane[7:0]};
      (ld_funct3 == F3_LHU):
        ld_data = {16'h0, lane[15:0]};
      default:
        ld_data = '0;
    endcase
  end

  // Shifted strobes are truncated to 4 bits on purpose.
  always_comb begin
    wstrb = '0;
    wdata = '0;
    unique case (1'b1)
      (st_funct3 == F3_SB): begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{st_src[7:0]}};
      end
      (st_funct3 == F3_SH): begin
        wstrb = 4'b0011 << st_off;
        wdata = {2{st_src[15:0]}};
      end
      (st_funct3 == F3_SW): begin
        wstrb = 4'b1111;
        wdata = st_src;
      end
      default: begin
        wstrb = '0;
        wdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage LSU: IDLE/REQ/RESP/DONE bus FSM with timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
import rv32_pkg::*;

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        busError,
  output logic        misaligned,
  load_store_unit_if.master bus
);

  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (CLOG > 8) ? CLOG : 8;

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        req_any;
  logic        is_store;
  logic        trap;
  logic        timeout;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign req_any  = memRead | memWrite;
  assign is_store = memWrite & ~memRead;
  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = req_any & is_misaligned(funct3, aluResult[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign memStall = ((state == IDLE) && req_any)
                 || (state == REQ)
                 || (state == RESP);

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_off    (aluResult[1:0]),
    .st_src    (storeData),
    .wstrb     (st_strb),
    .wdata     (st_data),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (bus.busRdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      readData        <= '0;
      busError        <= 1'b0;
      misaligned      <= 1'b0;
      bus.busReqValid <= 1'b0;
      bus.busWe       <= 1'b0;
      bus.busAddr     <= '0;
      bus.busWdata    <= '0;
      bus.busWstrb    <= '0;
    end else begin
      readData   <= '0;
      busError   <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trap) begin
            state      <= DONE;
            misaligned <= 1'b1;
          end else if (req_any) begin
            state           <= REQ;
            cnt             <= '0;
            f3_q            <= funct3;
            off_q           <= aluResult[1:0];
            bus.busReqValid <= 1'b1;
            bus.busWe       <= is_store;
            bus.busAddr     <= {aluResult[31:2], 2'b00};
            bus.busWdata    <= is_store ? st_data : '0;
            bus.busWstrb    <= is_store ? st_strb : '0;
          end
        end
        REQ: begin
          // Abandonment takes precedence over a late handshake.
          if (timeout) begin
            state           <= DONE;
            busError        <= 1'b1;
            bus.busReqValid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (bus.busReqReady) begin
              state           <= RESP;
              bus.busReqValid <= 1'b0;
            end
          end
        end
        RESP: begin
          if (timeout) begin
            state    <= DONE;
            busError <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (bus.busRespValid) begin
              state    <= DONE;
              readData <= bus.busWe ? '0 : ld_data;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: per-cycle expected
// trace built from access parameters, checked at negedge.
module tb_load_store_unit;

  localparam int TMO = 64;

  typedef struct {
    logic        stall;
    logic        rv;
    logic        err;
    logic        mis;
    logic [31:0] rd;
    bit          cb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic [31:0] readData;
  logic        memStall;
  logic        busError;
  logic        misaligned;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  load_store_unit_if bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .aluResult  (aluResult),
    .storeData  (storeData),
    .readData   (readData),
    .memStall   (memStall),
    .busError   (busError),
    .misaligned (misaligned),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, expv);
    end
  endtask

  // Reference model: plain arithmetic on lanes and sizes.
  function automatic logic [31:0] m_load(input logic [2:0] f3,
      input logic [1:0] off, input logic [31:0] w0);
    logic [31:0] w, b, h;
    w = w0 >> (8 * off);
    b = w % 256;
    h = w % 65536;
    case (f3)
      3'd0: return (b < 128) ? b : b - 32'd256;
      3'd1: return (h < 32768) ? h : h - 32'd65536;
      3'd2: return w0;
      3'd4: return b;
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3,
      input logic [1:0] off);
    logic [7:0] s;
    case (f3)
      3'd0: s = 8'd1 << off;
      3'd1: s = 8'd3 << off;
      3'd2: s = 8'd15;
      default: s = 8'd0;
    endcase
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
      input logic [31:0] sd);
    case (f3)
      3'd0: return (sd % 256) * 32'h01010101;
      3'd1: return (sd % 65536) * 32'h00010001;
      3'd2: return sd;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_misal(input logic [2:0] f3,
      input logic [1:0] off);
    return ((f3 % 4) == 1 && (off % 2) == 1)
        || ((f3 % 4) == 2 && off != 0);
  endfunction

  function automatic exp_t mk(input logic stall, input logic rv,
      input logic [31:0] rd, input logic err, input logic mis);
    exp_t e;
    e.stall = stall;
    e.rv    = rv;
    e.rd    = rd;
    e.err   = err;
    e.mis   = mis;
    e.cb    = 1'b0;
    e.we    = 1'b0;
    e.addr  = '0;
    e.wdata = '0;
    e.strb  = '0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("memStall", 32'(memStall), 32'(e.stall));
      chk("busReqValid", 32'(bus.busReqValid), 32'(e.rv));
      chk("readData", readData, e.rd);
      chk("busError", 32'(busError), 32'(e.err));
      chk("misaligned", 32'(misaligned), 32'(e.mis));
      if (e.cb) begin
        chk("busWe", 32'(bus.busWe), 32'(e.we));
        chk("busAddr", bus.busAddr, e.addr);
        chk("busWdata", bus.busWdata, e.wdata);
        chk("busWstrb", 32'(bus.busWstrb), 32'(e.strb));
      end
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    bus.busReqReady  = 1'($urandom % 2);
    bus.busRespValid = 1'($urandom % 2);
    bus.busRdata     = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      memRead   = 1'b0;
      memWrite  = 1'b0;
      funct3    = 3'($urandom);
      aluResult = $urandom;
      storeData = $urandom;
      junk();
      step(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
    end
  endtask

  // One access held by the pipeline until DONE. r/p are the
  // extra wait cycles before ready and before the response.
  task automatic access(input bit rd, input bit wr,
      input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] sd, input logic [31:0] rdat,
      input int r, input int p, input logic [31:0] erd,
      input logic [3:0] estrb, input logic [31:0] ewd);
    exp_t e;
    int c;
    bit trap, to, done, st;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = m_misal(f3, addr[1:0]);
`endif
    st = wr && !rd;
    memRead   = rd;
    memWrite  = wr;
    funct3    = f3;
    aluResult = addr;
    storeData = sd;
    junk();
    step(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0));
    if (trap) begin
      junk();
      step(mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1));
      return;
    end
    c = 0;
    to = 1'b0;
    done = 1'b0;
    for (int i = 0; !done; i++) begin
      c++;
      bus.busReqReady  = (i == r);
      bus.busRespValid = 1'($urandom % 2);
      bus.busRdata     = $urandom;
      e = mk(1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
      e.cb    = 1'b1;
      e.we    = st;
      e.addr  = addr & ~32'd3;
      e.strb  = estrb;
      e.wdata = ewd;
      step(e);
      if (c == TMO) begin
        to = 1'b1;
        done = 1'b1;
      end else if (i == r) begin
        done = 1'b1;
      end
    end
    done = to;
    for (int j = 0; !done; j++) begin
      c++;
      bus.busReqReady  = 1'($urandom % 2);
      bus.busRespValid = (j == p);
      bus.busRdata     = (j == p) ? rdat : $urandom;
      step(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0));
      if (c == TMO) begin
        to = 1'b1;
        done = 1'b1;
      end else if (j == p) begin
        done = 1'b1;
      end
    end
    junk();
    step(mk(1'b0, 1'b0, (to || st) ? 32'd0 : erd, to, 1'b0));
  endtask

  initial begin
    exp_t e;
    reset     = 1'b1;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    funct3    = 3'd0;
    aluResult = 32'd0;
    storeData = 32'd0;
    bus.busReqReady  = 1'b0;
    bus.busRespValid = 1'b0;
    bus.busRdata     = 32'd0;
    @(posedge clk);
    #1;
    e = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    e.cb = 1'b1;
    step(e);
    reset = 1'b0;
    idle(2);

    chk("model_lb", m_load(3'd0, 2'd3, 32'h80123456), 32'hFFFFFF80);
    chk("model_lbu", m_load(3'd4, 2'd3, 32'h80123456), 32'h00000080);
    chk("model_sh_strb", 32'(m_strb(3'd1, 2'd2)), 32'hC);
    chk("model_sh_data", m_wdata(3'd1, 32'h0000ABCD), 32'hABCDABCD);

    access(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0,
           32'hDEADBEEF, 4'h0, 32'h0);
    idle(1);
    access(1, 0, 3'd0, 32'h103, 0, 32'h80123456, 0, 0,
           32'hFFFFFF80, 4'h0, 32'h0);
    access(1, 0, 3'd4, 32'h103, 0, 32'h80123456, 1, 2,
           32'h00000080, 4'h0, 32'h0);
    access(0, 1, 3'd1, 32'h202, 32'h0000ABCD, 0, 2, 1,
           32'h0, 4'b1100, 32'hABCDABCD);
    access(1, 1, 3'd5, 32'h1FE, 32'h55, 32'h8001_7FFF, 0, 0,
           32'h00008001, 4'h0, 32'h0);
    idle(1);

    access(1, 0, 3'd2, 32'h400, 0, 32'h1, 70, 0,
           32'h1, 4'h0, 32'h0);
    idle(3);
    access(1, 0, 3'd2, 32'h404, 0, 32'h2, 30, 32,
           32'h2, 4'h0, 32'h0);
    access(1, 0, 3'd2, 32'h408, 0, 32'h3, 30, 31,
           32'h3, 4'h0, 32'h0);
    idle(1);

    memRead   = 1'b1;
    memWrite  = 1'b0;
    funct3    = 3'd2;
    aluResult = 32'h300;
    junk();
    step(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0));
    bus.busReqReady  = 1'b1;
    bus.busRespValid = 1'b0;
    e = mk(1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
    e.cb = 1'b1;
    e.addr = 32'h300;
    step(e);
    bus.busReqReady = 1'b0;
    step(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0));
    reset = 1'b1;
    step(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0));
    reset = 1'b0;
    memRead = 1'b0;
    bus.busRespValid = 1'b1;
    bus.busRdata = 32'h12345678;
    e = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    e.cb = 1'b1;
    step(e);
    step(e);
    idle(2);

`ifdef LSU_MISALIGN_TRAP_EN
    access(1, 0, 3'd2, 32'h101, 0, 32'h0, 0, 0,
           32'h0, 4'h0, 32'h0);
    access(0, 1, 3'd1, 32'h203, 32'h1234, 0, 0, 0,
           32'h0, 4'h0, 32'h0);
    idle(1);
`endif

    for (int n = 0; n < 200; n++) begin
      bit rd, wr;
      int sel, r, p;
      logic [2:0] f3;
      logic [31:0] addr, sd, rdat;
      sel = $urandom % 20;
      rd = (sel < 9) || (sel >= 18);
      wr = (sel >= 9);
      f3 = (wr && !rd) ? 3'($urandom % 3) : 3'($urandom % 8);
      addr = $urandom;
      sd = $urandom;
      rdat = $urandom;
      r = ($urandom % 25 == 0) ? $urandom_range(28, 66) : $urandom % 4;
      p = ($urandom % 25 == 0) ? $urandom_range(28, 40) : $urandom % 4;
      access(rd, wr, f3, addr, sd, rdat, r, p,
             m_load(f3, addr[1:0], rdat),
             (wr && !rd) ? m_strb(f3, addr[1:0]) : 4'h0,
             (wr && !rd) ? m_wdata(f3, sd) : 32'h0);
      idle($urandom % 3);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
